llc_bus_sequencer: RTL and testbench

//  Arbitrates LLC-side bus requests (miss fill, writeback, invalidate) onto the single shared system bus.

---
 rtl/llc_bus_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_llc_bus_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_bus_sequencer.sv
// llc_bus_sequencer: round-robin arbiter plus transaction sequencer that
// carries LLC fill/writeback/invalidate requests across the shared bus.
module llc_bus_sequencer #(
  parameter int NUM_REQ       = 3,
  parameter int CACHE_ID      = 0,
  parameter int SNOOP_TIMEOUT = 8,
  parameter int RETRY_DELAY   = 4,
  parameter int MAX_RETRY     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [3*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [1:0]            rsp_snoop,
  output logic                  rsp_err,
  output logic                  bus_valid,
  output logic [2:0]            bus_op,
  output logic [31:0]           bus_addr,
  output logic [3:0]            bus_cache_id,
  input  logic                  snoop_valid,
  input  logic [1:0]            snoop_result,
  input  logic                  bus_data_done,
  output logic                  busy,
  output logic [31:0]           cnt_read,
  output logic [31:0]           cnt_write
);

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_RWIM  = 3'd3;
  localparam logic [2:0] OP_INV   = 3'd4;
  localparam logic [1:0] SNP_NOHIT = 2'b00;
  localparam logic [1:0] SNP_HITM  = 2'b10;

  localparam int GW   = $clog2(NUM_REQ);
  localparam int TMAX = (SNOOP_TIMEOUT > RETRY_DELAY) ? SNOOP_TIMEOUT : RETRY_DELAY;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SNOOP,
    S_BACKOFF,
    S_DATA,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     addr_q, addr_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [1:0]      snp_q, snp_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [31:0]     cnt_read_q, cnt_read_d;
  logic [31:0]     cnt_write_q, cnt_write_d;

  logic [2:0]      op_arr   [NUM_REQ];
  logic [31:0]     addr_arr [NUM_REQ];
  logic            arb_hit;
  logic [GW-1:0]   arb_idx;
  logic [GW-1:0]   arb_cand;
  logic [2:0]      new_op;
  logic            new_legal;
  logic [1:0]      snp_now;
  logic            snp_end;
  logic            can_retry;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign op_arr[k]   = req_op[3*k +: 3];
    assign addr_arr[k] = req_addr[32*k +: 32];
  end

  // Scan downward so the lowest offset from the pointer wins.
  always_comb begin
    arb_hit  = 1'b0;
    arb_idx  = '0;
    arb_cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_cand = GW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[arb_cand]) begin
        arb_hit = 1'b1;
        arb_idx = arb_cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    retry_d     = retry_q;
    snp_d       = snp_q;
    err_d       = err_q;
    tmr_d       = tmr_q;
    cnt_read_d  = cnt_read_q;
    cnt_write_d = cnt_write_q;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_snoop    = '0;
    rsp_err      = 1'b0;
    bus_valid    = 1'b0;
    bus_op       = '0;
    bus_addr     = '0;
    bus_cache_id = '0;
    new_op    = op_arr[arb_idx];
    new_legal = (new_op != 3'd0) && (new_op <= OP_INV);
    // Reserved code 11 and a timeout both collapse to NOHIT.
    snp_now   = (snoop_valid && snoop_result != 2'b11) ? snoop_result : SNP_NOHIT;
    snp_end   = snoop_valid || (tmr_q == TW'(SNOOP_TIMEOUT - 1));
    can_retry = (op_q == OP_READ) || (op_q == OP_RWIM);
    unique case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          req_ready[arb_idx] = 1'b1;
          ptr_d   = (arb_idx == GW'(NUM_REQ - 1)) ? '0 : arb_idx + GW'(1);
          gnt_d   = arb_idx;
          op_d    = new_op;
          addr_d  = addr_arr[arb_idx];
          retry_d = '0;
          snp_d   = SNP_NOHIT;
          err_d   = !new_legal;
          state_d = new_legal ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        bus_valid    = 1'b1;
        bus_op       = op_q;
        bus_addr     = addr_q;
        bus_cache_id = 4'(CACHE_ID);
        tmr_d        = '0;
        state_d      = S_SNOOP;
      end
      S_SNOOP: begin
        tmr_d = tmr_q + 1'b1;
        if (snp_end) begin
          tmr_d = '0;
          snp_d = snp_now;
          if (snp_now == SNP_HITM && can_retry) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_d = retry_q + 1'b1;
              state_d = S_BACKOFF;
            end else begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          end else if (op_q == OP_INV) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_BACKOFF: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TW'(RETRY_DELAY - 1)) begin
          tmr_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_DATA: begin
        if (bus_data_done) state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_snoop = snp_q;
        rsp_err   = err_q;
        if (!err_q && op_q == OP_READ && cnt_read_q != '1)
          cnt_read_d = cnt_read_q + 32'd1;
        if (!err_q && op_q == OP_WRITE && cnt_write_q != '1)
          cnt_write_d = cnt_write_q + 32'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      retry_q     <= '0;
      snp_q       <= SNP_NOHIT;
      err_q       <= 1'b0;
      tmr_q       <= '0;
      cnt_read_q  <= '0;
      cnt_write_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      retry_q     <= retry_d;
      snp_q       <= snp_d;
      err_q       <= err_d;
      tmr_q       <= tmr_d;
      cnt_read_q  <= cnt_read_d;
      cnt_write_q <= cnt_write_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign cnt_read  = cnt_read_q;
  assign cnt_write = cnt_write_q;

endmodule

// File: tb/tb_llc_bus_sequencer.sv
// Bench for llc_bus_sequencer: randomized requests and bus responses
// checked cycle by cycle against a transaction-level timeline model.
module tb_llc_bus_sequencer;

  localparam int NR  = 3;
  localparam int TO  = 8;
  localparam int RD  = 4;
  localparam int MR  = 3;
  localparam logic [3:0] CID = 4'd5;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [3*NR-1:0] req_op;
  logic [32*NR-1:0] req_addr;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [1:0]      rsp_snoop;
  logic            rsp_err;
  logic            bus_valid;
  logic [2:0]      bus_op;
  logic [31:0]     bus_addr;
  logic [3:0]      bus_cache_id;
  logic            snoop_valid;
  logic [1:0]      snoop_result;
  logic            bus_data_done;
  logic            busy;
  logic [31:0]     cnt_read;
  logic [31:0]     cnt_write;

  int          total = 0;
  int          bad   = 0;
  int          m_ptr = 0;
  logic [31:0] m_rd  = 0;
  logic [31:0] m_wr  = 0;

  llc_bus_sequencer #(
    .NUM_REQ(NR), .CACHE_ID(5), .SNOOP_TIMEOUT(TO),
    .RETRY_DELAY(RD), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_snoop(rsp_snoop), .rsp_err(rsp_err),
    .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_cache_id(bus_cache_id),
    .snoop_valid(snoop_valid), .snoop_result(snoop_result),
    .bus_data_done(bus_data_done), .busy(busy),
    .cnt_read(cnt_read), .cnt_write(cnt_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // One transaction: build the expected timeline from the protocol rules,
  // then drive responses and compare every cycle until IDLE again.
  task automatic run_txn(input int g, input logic [2:0] op,
                         input logic [31:0] addr, input int sd_fix,
                         input int res_fix, input int dd_fix,
                         input bit noise, output int n_bus);
    bit          e_bus [128];
    bit          d_snp [128];
    logic [1:0]  v_snp [128];
    bit          d_dd  [128];
    int          c, s, e, sd, dd, j, done_c, wc;
    logic [1:0]  r, raw, e_snp;
    logic [NR-1:0] e_rv;
    bit          e_err, legal, fin, eb;
    for (int i = 0; i < 128; i++) begin
      e_bus[i] = 0; d_snp[i] = 0; v_snp[i] = 2'b00; d_dd[i] = 0;
    end
    legal  = (op >= 3'd1 && op <= 3'd4);
    e_snp  = 2'b00;
    e_err  = 0;
    n_bus  = 0;
    done_c = 1;
    if (!legal) e_err = 1;
    else begin
      c = 1; j = 0; fin = 0;
      while (!fin) begin
        e_bus[c] = 1;
        if (noise && $urandom_range(0, 1) == 1) begin
          d_snp[c] = 1; v_snp[c] = 2'b10;
        end
        s   = c + 1;
        sd  = (sd_fix >= 0) ? sd_fix : int'($urandom_range(0, TO));
        raw = (res_fix >= 0) ? 2'(res_fix) : 2'($urandom_range(0, 3));
        if (sd < TO) begin
          d_snp[s+sd] = 1; v_snp[s+sd] = raw;
          e = s + sd;
          r = (raw == 2'b11) ? 2'b00 : raw;
        end else begin
          e = s + TO - 1;
          r = 2'b00;
        end
        if (noise) d_dd[$urandom_range(s, e)] = 1;
        e_snp = r;
        if (r == 2'b10 && (op == 3'd1 || op == 3'd3) && j < MR) begin
          j++;
          if (noise) begin
            d_snp[e+1+int'($urandom_range(0, RD-1))] = 1;
            d_dd[e+1+int'($urandom_range(0, RD-1))] = 1;
          end
          c = e + RD + 1;
        end else begin
          fin = 1;
          if (r == 2'b10 && (op == 3'd1 || op == 3'd3)) begin
            e_err = 1; done_c = e + 1;
          end else if (op == 3'd4) begin
            done_c = e + 1;
          end else begin
            dd = (dd_fix >= 0) ? dd_fix : int'($urandom_range(0, 4));
            d_dd[e+1+dd] = 1;
            if (noise) begin
              d_snp[e+1] = 1; v_snp[e+1] = 2'b10;
            end
            done_c = e + 2 + dd;
          end
        end
      end
    end

    @(posedge clk); #1;
    req_valid = '0;
    req_valid[g] = 1'b1;
    req_op[3*g +: 3] = op;
    req_addr[32*g +: 32] = addr;
    snoop_valid = 0; bus_data_done = 0;
    wc = 0;
    @(negedge clk);
    while (req_ready == '0 && wc < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      wc++;
    end
    total++;
    if (req_ready !== (NR'(1) << g)) begin
      bad++;
      $display("FAIL grant req=%0d ready=%b want=%b", g, req_ready, NR'(1) << g);
      if (req_ready == '0) begin
        req_valid = '0;
        return;
      end
    end
    m_ptr = (g + 1) % NR;

    for (int cc = 1; cc <= done_c + 1; cc++) begin
      @(posedge clk); #1;
      if (cc == 1) req_valid = '0;
      snoop_valid   = d_snp[cc];
      snoop_result  = d_snp[cc] ? v_snp[cc] : 2'($urandom_range(0, 3));
      bus_data_done = d_dd[cc];
      @(negedge clk);
      if (bus_valid === 1'b1) n_bus++;
      eb = e_bus[cc];
      total++;
      if (bus_valid !== eb || bus_op !== (eb ? op : 3'd0) ||
          bus_addr !== (eb ? addr : 32'd0) ||
          bus_cache_id !== (eb ? CID : 4'd0)) begin
        bad++;
        $display("FAIL bus cyc=%0d got v=%b op=%0d a=%h id=%0d want v=%b op=%0d a=%h",
                 cc, bus_valid, bus_op, bus_addr, bus_cache_id, eb, op, addr);
      end
      e_rv = (cc == done_c) ? (NR'(1) << g) : '0;
      total++;
      if (rsp_valid !== e_rv) begin
        bad++;
        $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cc, rsp_valid, e_rv);
      end
      if (cc == done_c) begin
        total++;
        if (rsp_snoop !== e_snp || rsp_err !== e_err) begin
          bad++;
          $display("FAIL rsp_data op=%0d got snp=%b err=%b want snp=%b err=%b",
                   op, rsp_snoop, rsp_err, e_snp, e_err);
        end
      end
      total++;
      if (busy !== (cc <= done_c)) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cc, busy, cc <= done_c);
      end
    end
    snoop_valid = 0; bus_data_done = 0;
    if (!e_err && op == 3'd1 && m_rd != 32'hFFFF_FFFF) m_rd++;
    if (!e_err && op == 3'd2 && m_wr != 32'hFFFF_FFFF) m_wr++;
    total++;
    if (cnt_read !== m_rd || cnt_write !== m_wr) begin
      bad++;
      $display("FAIL counters got rd=%h wr=%h want rd=%h wr=%h",
               cnt_read, cnt_write, m_rd, m_wr);
    end
  endtask

  task automatic test_reset();
    rst = 1; req_valid = '0; req_op = '0; req_addr = '0;
    snoop_valid = 0; snoop_result = 2'b00; bus_data_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_snoop, rsp_err, bus_valid, bus_op,
         bus_addr, bus_cache_id, busy, cnt_read, cnt_write} !== '0) begin
      bad++;
      $display("FAIL reset_hold outputs nonzero bv=%b busy=%b rd=%h", bus_valid, busy, cnt_read);
    end
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_snoop, rsp_err, bus_valid, bus_op,
         bus_addr, bus_cache_id, busy, cnt_read, cnt_write} !== '0) begin
      bad++;
      $display("FAIL reset_idle outputs nonzero bv=%b busy=%b rd=%h", bus_valid, busy, cnt_read);
    end
    m_ptr = 0; m_rd = 0; m_wr = 0;
  endtask

  task automatic test_round_robin();
    bit          pend [NR];
    logic [31:0] ad [NR];
    logic [31:0] cur_ad;
    int          first_g [4] = '{0, 1, 2, 0};
    int          t_g, cur_g, eg, ngr;
    logic [1:0]  exp_snp;
    logic [NR-1:0] want;
    bit          anyp, found;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1; ad[i] = $urandom;
    end
    t_g = -10; cur_g = 0; ngr = 0; exp_snp = 0; cur_ad = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = pend[i];
        req_op[3*i +: 3] = 3'd4;
        req_addr[32*i +: 32] = ad[i];
      end
      snoop_valid = 1;
      snoop_result = 2'($urandom_range(0, 3));
      @(negedge clk);
      anyp = 0;
      for (int i = 0; i < NR; i++) anyp |= pend[i];
      if (cyc == t_g + 2) exp_snp = (snoop_result == 2'b11) ? 2'b00 : snoop_result;
      total++;
      if (anyp && cyc >= t_g + 4) begin
        eg = 0; found = 0;
        for (int k = 0; k < NR; k++)
          if (!found && pend[(m_ptr + k) % NR]) begin
            eg = (m_ptr + k) % NR; found = 1;
          end
        if (req_ready !== (NR'(1) << eg)) begin
          bad++;
          $display("FAIL rr_grant cyc=%0d got=%b want=%b", cyc, req_ready, NR'(1) << eg);
        end
        if (ngr < 4) begin
          total++;
          if (req_ready !== (NR'(1) << first_g[ngr])) begin
            bad++;
            $display("FAIL rr_order n=%0d got=%b want=%b", ngr, req_ready,
                     NR'(1) << first_g[ngr]);
          end
        end
        m_ptr = (eg + 1) % NR;
        cur_g = eg; cur_ad = ad[eg]; t_g = cyc; ngr++;
        pend[eg] = (ngr < 4) ? 1'b1 : ((ngr < 8) ? 1'($urandom_range(0, 1)) : 1'b0);
      end else if (req_ready !== '0) begin
        bad++;
        $display("FAIL rr_idle_ready cyc=%0d got=%b want=0", cyc, req_ready);
      end
      total++;
      if (bus_valid !== (cyc == t_g + 1) ||
          (cyc == t_g + 1 && (bus_op !== 3'd4 || bus_addr !== cur_ad ||
                              bus_cache_id !== CID))) begin
        bad++;
        $display("FAIL rr_bus cyc=%0d got v=%b op=%0d a=%h want v=%b a=%h",
                 cyc, bus_valid, bus_op, bus_addr, cyc == t_g + 1, cur_ad);
      end
      want = (cyc == t_g + 3) ? (NR'(1) << cur_g) : '0;
      total++;
      if (rsp_valid !== want ||
          (cyc == t_g + 3 && (rsp_snoop !== exp_snp || rsp_err !== 1'b0))) begin
        bad++;
        $display("FAIL rr_rsp cyc=%0d got v=%b s=%b e=%b want v=%b s=%b e=0",
                 cyc, rsp_valid, rsp_snoop, rsp_err, want, exp_snp);
      end
      if (ngr < 8)
        for (int i = 0; i < NR; i++)
          if (!pend[i] && $urandom_range(0, 2) == 0) begin
            pend[i] = 1; ad[i] = $urandom;
          end
      anyp = 0;
      for (int i = 0; i < NR; i++) anyp |= pend[i];
      if (ngr >= 8 && !anyp && cyc >= t_g + 4) break;
    end
    @(posedge clk); #1;
    snoop_valid = 0; req_valid = '0;
    @(negedge clk);
    total++;
    if (cnt_read !== m_rd || cnt_write !== m_wr || busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_counters got rd=%h wr=%h busy=%b want rd=%h wr=%h busy=0",
               cnt_read, cnt_write, busy, m_rd, m_wr);
    end
  endtask

  task automatic test_read_basic();
    int nb;
    run_txn(0, 3'd1, 32'h0000_1000, 0, 1, 1, 0, nb);
  endtask

  task automatic test_rwim_retry();
    int nb;
    run_txn(1, 3'd3, 32'hABCD_0040, int'($urandom_range(0, TO-1)), 2, 0, 0, nb);
    total++;
    if (nb !== MR + 1) begin
      bad++;
      $display("FAIL rwim_issues got=%0d want=%0d", nb, MR + 1);
    end
  endtask

  task automatic test_write_hitm();
    int nb;
    run_txn(2, 3'd2, 32'h0BAD_BEE0, int'($urandom_range(0, TO-1)), 2, -1, 0, nb);
    total++;
    if (nb !== 1) begin
      bad++;
      $display("FAIL write_issues got=%0d want=1", nb);
    end
  endtask

  task automatic test_illegal_and_timeout();
    int nb;
    run_txn(0, 3'b111, 32'h1234_5678, 0, 0, 0, 0, nb);
    run_txn(2, 3'b000, 32'h1234_5678, 0, 0, 0, 0, nb);
    run_txn(0, 3'd1, 32'h0000_2000, TO, 0, 0, 0, nb);
    run_txn(1, 3'd4, 32'h0000_3000, TO, 0, 0, 0, nb);
  endtask

  task automatic test_random();
    int nb, x;
    logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      x  = int'($urandom_range(0, 9));
      op = (x < 8) ? 3'(1 + x / 2) : ((x == 8) ? 3'd0 : 3'(5 + $urandom_range(0, 2)));
      run_txn(int'($urandom_range(0, NR-1)), op, $urandom, -1, -1, -1, 1, nb);
    end
  endtask

  task automatic test_reset_mid_data();
    @(posedge clk); #1;
    req_valid = '0; req_valid[0] = 1'b1;
    req_op[2:0] = 3'd1; req_addr[31:0] = 32'h0000_5000;
    @(negedge clk);
    total++;
    if (req_ready !== NR'(1)) begin
      bad++;
      $display("FAIL rst_grant got=%b want=001", req_ready);
    end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1; snoop_valid = 1; snoop_result = 2'b00;
    @(posedge clk); #1; snoop_valid = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || rsp_valid !== '0) begin
      bad++;
      $display("FAIL rst_in_data got busy=%b rsp=%b want busy=1 rsp=0", busy, rsp_valid);
    end
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    m_ptr = 0; m_rd = 0; m_wr = 0;
    total++;
    if ({req_ready, rsp_valid, rsp_snoop, rsp_err, bus_valid, bus_op,
         bus_addr, bus_cache_id, busy, cnt_read, cnt_write} !== '0) begin
      bad++;
      $display("FAIL rst_abort outputs nonzero busy=%b rsp=%b rd=%h wr=%h",
               busy, rsp_valid, cnt_read, cnt_write);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; bus_data_done = 1;
      @(negedge clk);
      total++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_no_rsp got rsp=%b busy=%b want 0 0", rsp_valid, busy);
      end
    end
    bus_data_done = 0;
  endtask

  task automatic test_saturate();
    int nb;
    @(posedge clk); #1;
    force dut.cnt_read_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    release dut.cnt_read_q;
    m_rd = 32'hFFFF_FFFF;
    run_txn(1, 3'd1, 32'h2000_0040, 0, 1, 0, 0, nb);
    run_txn(2, 3'd2, 32'h2000_0080, 1, 0, 2, 0, nb);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read_basic();
    test_rwim_retry();
    test_write_hitm();
    test_illegal_and_timeout();
    test_random();
    test_reset_mid_data();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
